// File: rtl/issue_instr_queue.sv
// issue_instr_queue: decode-to-issue decoupling FIFO with a valid/ack handshake towards issue and a flush.
// Optional macro ISSUE_Q_BYPASS_EN adds a zero-latency forward path when the queue is empty.
module issue_instr_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ENTRY_WIDTH = 128,
  parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   stall_i,
  input  logic                   dec_valid_i,
  output logic                   dec_ready_o,
  input  logic [ENTRY_WIDTH-1:0] dec_entry_i,
  input  logic [31:0]            dec_orig_instr_i,
  input  logic                   dec_is_ctrl_flow_i,
  output logic [ENTRY_WIDTH-1:0] decoded_instr_o,
  output logic [31:0]            orig_instr_o,
  output logic                   is_ctrl_flow_o,
  output logic                   decoded_instr_valid_o,
  input  logic                   decoded_instr_ack_i,
  output logic [CNT_W-1:0]       count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ENTRY_WIDTH-1:0] entry;
    logic [31:0]            orig_instr;
    logic                   ctrl_flow;
  } slot_t;

  slot_t            mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] cnt_r;

  slot_t in_slot_s;
  slot_t head_s;
  slot_t out_slot_s;
  logic  empty_s;
  logic  full_s;
  logic  bypass_s;
  logic  valid_s;
  logic  push_s;
  logic  pop_s;

  // Handshake decode: occupancy flags, head selection, push/pop qualification.
  always_comb begin
    in_slot_s = {dec_entry_i, dec_orig_instr_i, dec_is_ctrl_flow_i};
    head_s    = mem_r[rd_ptr_r];
    empty_s   = (cnt_r == CNT_W'(0));
    full_s    = (cnt_r == CNT_W'(DEPTH));
`ifdef ISSUE_Q_BYPASS_EN
    bypass_s  = empty_s & dec_valid_i & ~stall_i;
`else
    bypass_s  = 1'b0;
`endif
    valid_s   = bypass_s | (~empty_s & ~stall_i);
    if (bypass_s) begin
      out_slot_s = in_slot_s;
    end else begin
      out_slot_s = head_s;
    end
    // A bypassed entry that is acked never touches storage.
    pop_s  = valid_s & decoded_instr_ack_i & ~flush_i & ~bypass_s;
    push_s = dec_valid_i & ~full_s & ~flush_i & ~(bypass_s & decoded_instr_ack_i);
  end

  assign dec_ready_o           = ~full_s;
  assign decoded_instr_valid_o = valid_s;
  assign decoded_instr_o       = out_slot_s.entry;
  assign orig_instr_o          = out_slot_s.orig_instr;
  assign is_ctrl_flow_o        = out_slot_s.ctrl_flow;
  assign count_o               = cnt_r;

  // Pointer and occupancy state; flush behaves like a reset of the control state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_r <= PTR_W'(0);
      wr_ptr_r <= PTR_W'(0);
      cnt_r    <= CNT_W'(0);
    end else if (flush_i) begin
      rd_ptr_r <= PTR_W'(0);
      wr_ptr_r <= PTR_W'(0);
      cnt_r    <= CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_slot_s;
    end
  end

endmodule

// File: doc/issue_instr_queue.md
Name: issue_instr_queue

Overview:
- Decoupling FIFO on the transmit side of the decode-to-issue handshake.
- Accepts decoded scoreboard entries from the decoder and presents them to the issue stage with a valid/ack handshake: decoded_instr_valid_o out, decoded_instr_ack_i in.
- Absorbs issue back-pressure so that decode keeps running, and discards all queued entries on a flush.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- ENTRY_WIDTH, 128: width of the flattened scoreboard entry.
- CNT_W, $clog2(DEPTH+1): width of the occupancy counter.

Ports:
- clk_i  in  1  subsystem clock
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  drop all entries (controller flush_unissued_instr)
- stall_i  in  1  accelerator-dispatcher stall; masks the output valid only
- dec_valid_i  in  1  decoder presents an entry
- dec_ready_o  out  1  queue can accept an entry
- dec_entry_i  in  ENTRY_WIDTH  decoded scoreboard entry
- dec_orig_instr_i  in  32  raw instruction word
- dec_is_ctrl_flow_i  in  1  entry is a control-flow instruction
- decoded_instr_o  out  ENTRY_WIDTH  head entry
- orig_instr_o  out  32  head raw instruction
- is_ctrl_flow_o  out  1  head control-flow flag
- decoded_instr_valid_o  out  1  head is valid towards issue
- decoded_instr_ack_i  in  1  issue consumed the head
- count_o  out  CNT_W  current occupancy

Behaviour:
- **Storage:** circular buffer of DEPTH entries. Each entry holds {entry, orig_instr, ctrl_flow}. Read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. A separate counter cnt tracks occupancy, 0..DEPTH.
- **Reset:** on a rising clock edge with rst_ni=0:
  - rd_ptr, wr_ptr and cnt all go to 0.
  - Outputs after reset: dec_ready_o=1, decoded_instr_valid_o=0, count_o=0.
  - Data outputs equal storage[0]; their contents are don't-care while valid=0.
- **Push:** push = dec_valid_i & dec_ready_o & !flush_i.
  - dec_ready_o = (cnt != DEPTH). It does not depend on ack in the same cycle, so there is no combinational path from ack to ready.
- **Pop:** pop = decoded_instr_valid_o & decoded_instr_ack_i & !flush_i.
  - decoded_instr_valid_o = (cnt != 0) & !stall_i.
  - Head data outputs are read combinationally from storage[rd_ptr].
- **Latency:** a pushed entry is visible at the output on the cycle after the push; minimum latency is 1 cycle.
- **Simultaneous push and pop:** both pointers advance and cnt is unchanged. This is legal at any non-full occupancy, including cnt=1, where the popped entry differs from the written one.
- **Full:** cnt=DEPTH gives ready=0 and no write. A pop in the same cycle frees a slot that is usable from the next cycle.
- **Empty:** valid=0. An ack while valid=0 is ignored and the pointers do not move.
- **Stall:** stall_i=1 forces valid=0. A push is still accepted if the queue is not full. Entries and order are preserved.
- **Flush:** flush_i=1 at an edge sets rd_ptr=wr_ptr=0 and cnt=0 in the next cycle.
  - Any push or ack in that cycle is discarded.
  - During the flush cycle itself, valid and ready still reflect the pre-flush state. The issue side must ignore the handshake in that cycle.
- **Precedence:** reset > flush > push/pop.
- **Reset mid-operation:** all entries are lost; the queue behaves as after power-up.
- **Ordering:** strict FIFO; an entry is never duplicated or skipped.

Optional Feature:
- Macro: ISSUE_Q_BYPASS_EN.
- **Defined:** when cnt=0, dec_valid_i=1 and stall_i=0:
  - The input entry is forwarded combinationally to the outputs and decoded_instr_valid_o=1 in the same cycle.
  - If decoded_instr_ack_i=1, the entry is consumed without being written: pointers and cnt are unchanged.
  - Otherwise it is written normally.
  - Minimum latency becomes 0.
- **Not defined:** no bypass; minimum latency is 1 cycle as described above.

Test Plan:
- **Reset and empty:** hold rst_ni=0 for 2 cycles, then release -> valid=0, ready=1, count_o=0. An ack while empty leaves count_o=0.
- **Fill and order:** push orig 0x00000013, 0x00100093, 0x00200113, 0x00300193 with ack=0 -> count_o=4 and ready=0. A 5th push is refused. Then hold ack=1 -> outputs appear in push order on 4 consecutive cycles, then valid=0.
- **Concurrent push/pop:** at cnt=2, push and ack together for 6 cycles -> count_o stays 2. Output sequence equals input sequence, with pointers wrapping past DEPTH-1.
- **Stall:** cnt=2 and stall_i=1 for 3 cycles with ack=1 -> valid=0 and count_o=2. Then stall_i=0 -> the head is the original first entry.
- **Flush:** cnt=3 with push and ack in the flush cycle -> next cycle count_o=0 and valid=0. A following push of 0x00400213 emerges first.
- **Bypass (ISSUE_Q_BYPASS_EN):**
  - Empty queue, push 0x00500293 with ack=1 -> valid=1 in the same cycle, and count_o stays 0.
  - Without the macro -> valid=0 in that cycle and 1 in the next.
